// File: rtl/pc_unit.sv
// Program-counter unit: BOOT/RUN sequencer that selects the next fetch address
// from exceptions, redirects, exception return and sequential advance.
module pc_unit #(
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_VEC = '0,
  parameter logic [ADDR_W-1:0]  EXC_VEC   = ADDR_W'(32'h0000_0080),
  parameter int                 STEP      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              imem_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              exc_req,
  input  logic              eret,
  output logic [ADDR_W-1:0] pc_out,
  output logic              pc_valid,
  output logic [ADDR_W-1:0] epc_out,
  output logic              misalign
);

  typedef enum logic {
    BOOT,
    RUN
  } state_t;

  // STEP is a power of two, so the low bits below it flag a misaligned target.
  localparam logic [ADDR_W-1:0] STEP_MASK = ADDR_W'(STEP - 1);
  localparam logic [ADDR_W-1:0] STEP_INC  = ADDR_W'(STEP);

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc_next, epc_next;
  logic              misalign_next;
  logic              redirect_misaligned;

  assign redirect_misaligned = redirect_valid && ((redirect_addr & STEP_MASK) != '0);
  assign pc_valid            = (state == RUN);

  // NOTE: every output of this block gets a default before the case so that
  // no path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_next    = state;
    pc_next       = pc_out;
    epc_next      = epc_out;
    misalign_next = 1'b0;
    unique case (state)
      BOOT: state_next = RUN;
      RUN: begin
        if (exc_req) begin
          epc_next = pc_out;
          pc_next  = EXC_VEC;
        end else if (redirect_misaligned) begin
          epc_next      = redirect_addr;
          pc_next       = EXC_VEC;
          misalign_next = 1'b1;
        end else if (eret) begin
          pc_next = epc_out;
        end else if (redirect_valid) begin
          pc_next = redirect_addr;
        end else if (imem_ready && !stall) begin
          pc_next = pc_out + STEP_INC;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      pc_out   <= RESET_VEC;
      epc_out  <= '0;
      misalign <= 1'b0;
    end else begin
      state    <= state_next;
      pc_out   <= pc_next;
      epc_out  <= epc_next;
      misalign <= misalign_next;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit with default parameters.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        imem_ready;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        exc_req;
  logic        eret;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic [31:0] epc_out;
  logic        misalign;

  int errors = 0;
  int checks = 0;

  pc_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .imem_ready     (imem_ready),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .exc_req        (exc_req),
    .eret           (eret),
    .pc_out         (pc_out),
    .pc_valid       (pc_valid),
    .epc_out        (epc_out),
    .misalign       (misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall          = 1'b0;
    imem_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    exc_req        = 1'b0;
    eret           = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] epc,
                           input logic valid, input logic mis);
    check({tag, ".pc"},       pc_out,            pc);
    check({tag, ".epc"},      epc_out,           epc);
    check({tag, ".valid"},    {31'b0, pc_valid}, {31'b0, valid});
    check({tag, ".misalign"}, {31'b0, misalign}, {31'b0, mis});
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    check_all("reset1", 32'h0, 32'h0, 1'b0, 1'b0);
    exc_req = 1'b1;
    tick();
    check_all("reset_hold", 32'h0, 32'h0, 1'b0, 1'b0);

    // First edge after release is BOOT: the pending exception must be ignored.
    rst = 1'b0;
    tick();
    check_all("boot_exit", 32'h0, 32'h0, 1'b1, 1'b0);
    exc_req = 1'b0;
    tick(); check("adv4",  pc_out, 32'h4);
    tick(); check("adv8",  pc_out, 32'h8);
    tick(); check("adv12", pc_out, 32'hC);
    tick(); check("adv16", pc_out, 32'h10);

    stall = 1'b1;
    tick(); check("stall1", pc_out, 32'h10);
    tick(); check("stall2", pc_out, 32'h10);
    tick(); check("stall3", pc_out, 32'h10);
    redirect_valid = 1'b1; redirect_addr = 32'h200;
    tick(); check("redir_stalled", pc_out, 32'h200);

    stall = 1'b0; imem_ready = 1'b0; redirect_valid = 1'b0;
    tick(); check("imem_not_ready", pc_out, 32'h200);
    imem_ready = 1'b1;

    redirect_valid = 1'b1; redirect_addr = 32'h40;
    tick(); check("redir_40", pc_out, 32'h40);
    exc_req = 1'b1; redirect_addr = 32'h300;
    tick(); check_all("exc_over_redir", 32'h80, 32'h40, 1'b1, 1'b0);
    idle_inputs();
    tick(); check("exc_handler_adv", pc_out, 32'h84);
    stall = 1'b1; eret = 1'b1;
    tick(); check_all("eret", 32'h40, 32'h40, 1'b1, 1'b0);

    idle_inputs();
    redirect_valid = 1'b1; redirect_addr = 32'h102;
    tick(); check_all("misalign", 32'h80, 32'h102, 1'b1, 1'b1);
    idle_inputs();
    tick(); check_all("misalign_clear", 32'h84, 32'h102, 1'b1, 1'b0);

    // Misaligned redirect outranks eret; eret outranks an aligned redirect.
    redirect_valid = 1'b1; redirect_addr = 32'h106; eret = 1'b1;
    tick(); check_all("mis_over_eret", 32'h80, 32'h106, 1'b1, 1'b1);
    redirect_addr = 32'h500;
    tick(); check_all("eret_over_redir", 32'h106, 32'h106, 1'b1, 1'b0);

    idle_inputs();
    redirect_valid = 1'b1; redirect_addr = 32'hFFFF_FFFC;
    tick(); check_all("redir_top", 32'hFFFF_FFFC, 32'h106, 1'b1, 1'b0);
    idle_inputs();
    tick(); check_all("wrap", 32'h0, 32'h106, 1'b1, 1'b0);
    tick(); check("wrap_adv", pc_out, 32'h4);

    exc_req = 1'b1;
    tick(); check_all("exc_before_rst", 32'h80, 32'h4, 1'b1, 1'b0);
    exc_req = 1'b0; stall = 1'b1; rst = 1'b1;
    tick(); check_all("rst_mid_exc", 32'h0, 32'h0, 1'b0, 1'b0);

    rst = 1'b0; stall = 1'b0;
    tick(); check_all("reboot", 32'h0, 32'h0, 1'b1, 1'b0);
    tick(); check("reboot_adv", pc_out, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter ADDR_W, default 32, sets the program-counter width in bits.
REQ-002 Parameter RESET_VEC, default 0, is the first fetch address after reset.
REQ-003 Parameter EXC_VEC, default 32'h0000_0080, is the exception handler entry address.
REQ-004 Parameter STEP, default 4, is the sequential increment in bytes.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 stall  input  1  freeze sequential advance (pipeline hazard).
REQ-008 imem_ready  input  1  instruction memory accepted the current pc_out this cycle.
REQ-009 redirect_valid  input  1  branch/jump taken this cycle.
REQ-010 redirect_addr  input  ADDR_W  branch/jump target.
REQ-011 exc_req  input  1  exception request.
REQ-012 eret  input  1  return from exception.
REQ-013 pc_out  output  ADDR_W  current fetch address (registered).
REQ-014 pc_valid  output  1  pc_out is a valid fetch request.
REQ-015 epc_out  output  ADDR_W  saved exception PC (registered).
REQ-016 misalign  output  1  one-cycle pulse: redirect target not STEP-aligned.

Function
REQ-017 The FSM SHALL have two states: BOOT and RUN.
REQ-018 BOOT SHALL last exactly one cycle with pc_valid=0, then go to RUN unconditionally; all event inputs are ignored in BOOT.
REQ-019 In RUN, pc_valid SHALL be 1.
REQ-020 In RUN, the next pc_out SHALL be selected by fixed priority: exc_req > misaligned redirect > eret > redirect_valid > advance > hold.
REQ-021 exc_req: epc_out <= pc_out, pc_out <= EXC_VEC; taken regardless of stall/imem_ready.
REQ-022 Misaligned redirect (redirect_valid=1 and redirect_addr mod STEP != 0, STEP a power of two): pc_out <= EXC_VEC, epc_out <= redirect_addr, misalign=1 for the next cycle only.
REQ-023 eret: pc_out <= epc_out, epc_out unchanged; taken regardless of stall/imem_ready.
REQ-024 Aligned redirect: pc_out <= redirect_addr; taken regardless of stall/imem_ready.
REQ-025 Advance (imem_ready=1 and stall=0): pc_out <= pc_out + STEP, modulo 2^ADDR_W (wrap to 0, no flag).
REQ-026 Hold (no event; stall=1 or imem_ready=0): pc_out, epc_out unchanged.
REQ-027 Every redirect/exception/eret SHALL take effect on pc_out one cycle after being sampled; no added latency.
REQ-028 epc_out SHALL change only under REQ-021 or REQ-022.
REQ-029 misalign SHALL be 0 in every cycle not following a REQ-022 event.

Reset
REQ-030 With rst=1 at a rising edge: state <= BOOT, pc_out <= RESET_VEC, epc_out <= 0, misalign <= 0, pc_valid <= 0.
REQ-031 rst SHALL override every other input, including mid-exception or mid-stall; no pending event survives reset.
REQ-032 Outputs SHALL hold reset values while rst stays asserted.

Verification
REQ-033 Release rst, imem_ready=1, stall=0 -> pc_valid 0 for one cycle, then pc_out 0,4,8,12 on successive cycles.
REQ-034 pc_out=0x10, stall=1 for 3 cycles, then redirect_valid=1, redirect_addr=0x200 while stalled -> pc_out stays 0x10 for the stalled cycles, then 0x200 the cycle after the redirect.
REQ-035 pc_out=0x40, exc_req=1 and redirect_valid=1 (0x300) same cycle -> pc_out=0x80, epc_out=0x40; eret later -> pc_out=0x40.
REQ-036 redirect_addr=0x102 -> pc_out=0x80, epc_out=0x102, misalign=1 for exactly one cycle.
REQ-037 Force pc_out=0xFFFF_FFFC with an aligned redirect, then advance -> pc_out=0x0000_0000; misalign stays 0.
REQ-038 Assert rst during a stalled cycle right after an exception -> next cycle pc_out=RESET_VEC, epc_out=0, pc_valid=0.
